button_mmio_in: RTL
===================

Name: button_mmio_in

Overview:
- Memory-mapped input peripheral: the CPU-read counterpart of the seven-segment display output path in the data memory.
- Synchronises and debounces the `up`/`down` push-buttons, then detects press edges.
- Keeps sticky pending flags and saturating press counters per button.
- The MIPS core reads these registers, and clears them, over the same data-memory bus signals it uses for `dmemory` (`memread`, `memwrite`, `adr`, `writedata`).

Parameters:
- WIDTH, 32, bus data/address width.
- DB_CYCLES, 1000000, cycles a raw level must stay stable before acceptance (≥2).
- CNT_BITS, 8, width of each press counter (≤WIDTH).
- BASE_ADR, 32'h0000_FF00, 16-byte-aligned base of the register window.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- up  in  1  raw asynchronous button.
- down  in  1  raw asynchronous button.
- memread  in  1  CPU read strobe.
- memwrite  in  1  CPU write strobe.
- adr  in  WIDTH  byte address.
- writedata  in  WIDTH  CPU write data.
- hit  out  1  combinational: adr[WIDTH-1:4]==BASE_ADR[WIDTH-1:4].
- rdata  out  WIDTH  registered read data.
- irq  out  1  OR of pending flags (registered).

Behaviour:
- Reset (reset==0, async) clears everything: synchroniser flops, debounce counters, stable levels, pending flags, counters, rdata, irq.
- Synchroniser: 2 flops per button. Raw-to-sync latency is 2 cycles.
- Debounce, per button:
  - If sync==stable, dcnt<=0.
  - Else dcnt increments. When dcnt==DB_CYCLES-1, stable<=sync and dcnt<=0.
  - Any glitch returning to the stable value before acceptance restarts dcnt.
- Press pulse: one-cycle pulse on a stable 0→1 transition. Release generates nothing.
- Register map (offset = adr[3:0]):
  - 0x0 STATUS: [0] up_stable, [1] down_stable, [2] up_pending, [3] down_pending, rest 0.
  - 0x4 UPCNT: counter zero-extended.
  - 0x8 DNCNT: counter zero-extended.
  - 0xC and unaligned offsets read 0.
- Pending flag: set by press pulse. A write to 0x0 with writedata[2]/[3]=1 clears the corresponding flag (write-1-to-clear); 0 bits leave the flag unchanged.
- Counter update:
  - Press pulse increments the counter, saturating at 2^CNT_BITS-1 (no wrap).
  - Any write to 0x4/0x8 clears that counter (data ignored).
- Simultaneous events, same cycle:
  - Press pulse + W1C of the same flag → flag stays 1.
  - Press pulse + counter clear → counter becomes 1.
  - No press is ever lost.
- Read: if memread && hit at edge N, rdata reflects the register value sampled at edge N and is valid after edge N (one-cycle latency). Otherwise rdata<=0.
- Read/write in the same cycle: the read returns the pre-write value.
- Writes with hit==0 are ignored. memread and memwrite are independent.
- irq <= up_pending|down_pending, one cycle after the flag changes.
- Reset asserted mid-debounce or mid-read aborts immediately. After release, all state starts from zero and buttons held high need a full DB_CYCLES to register.

Decomposition:
- Shared package holds:
  - register offsets (OFS_STATUS=0x0, OFS_UPCNT=0x4, OFS_DNCNT=0x8);
  - STATUS bit indices;
  - the default BASE_ADR.
- Sub-module `button_debounce` (params DB_CYCLES): ports clk, reset, raw; outputs stable, press. It contains the synchroniser, debounce counter and edge detector, and is instantiated twice.
- The top level holds the register file, address decode, and read mux.

Test Plan (DB_CYCLES=4, CNT_BITS=3, BASE_ADR=0xFF00):
- Reset values: reset low with up=1, then release and read 0xFF00 each cycle → rdata=0 until cycle 2+4 after release, then STATUS=0x5 (up_stable, up_pending); irq=1 one cycle after the flag.
- Glitch rejection: up high for 3 cycles, then low → no pending, UPCNT reads 0.
- Saturation: 9 clean down presses → DNCNT=7.
- Clear: write 0xFF08 → next read of DNCNT is 0; a press on the clear cycle gives 1.
- W1C precedence: pending set, write 0xFF00 data 0x4 in the same cycle as a new up press → up_pending stays 1. A write with no press → 0, and irq drops the next cycle.
- Unmapped and mid-operation reset:
  - Read 0xFF0C → 0; read 0xFE00 → hit=0, rdata=0.
  - Write 0xFE04 leaves UPCNT unchanged.
  - Assert reset mid-debounce → all outputs 0 asynchronously.

Source files
------------

// File: rtl/button_mmio_in_pkg.sv
// rtl/button_mmio_in_pkg.sv - register offsets, STATUS layout and defaults for button_mmio_in
package button_mmio_in_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADR = 32'h0000_FF00;

  localparam logic [3:0] OFS_STATUS = 4'h0;
  localparam logic [3:0] OFS_UPCNT  = 4'h4;
  localparam logic [3:0] OFS_DNCNT  = 4'h8;

  localparam int ST_UP_STABLE    = 0;
  localparam int ST_DOWN_STABLE  = 1;
  localparam int ST_UP_PENDING   = 2;
  localparam int ST_DOWN_PENDING = 3;

  typedef enum logic [1:0] {
    REG_STATUS,
    REG_UPCNT,
    REG_DNCNT,
    REG_NONE
  } reg_sel_e;

  // Only exact word offsets select a register; 0xC and unaligned offsets fall to REG_NONE.
  function automatic reg_sel_e decode_ofs(input logic [3:0] ofs);
    case (ofs)
      OFS_STATUS: return REG_STATUS;
      OFS_UPCNT:  return REG_UPCNT;
      OFS_DNCNT:  return REG_DNCNT;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/button_mmio_in_debounce.sv
// rtl/button_mmio_in_debounce.sv - two-flop synchroniser, debounce counter and press detector
module button_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int DCW = $clog2(DB_CYCLES);
  localparam logic [DCW-1:0] DCNT_LAST = DCW'(DB_CYCLES - 1);

  logic           sync1;
  logic           sync2;
  logic [DCW-1:0] dcnt;
  logic           accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The new level is taken on the DB_CYCLES-th consecutive cycle it differs from stable.
  assign accept = (sync2 != stable) && (dcnt == DCNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcnt   <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      dcnt <= '0;
    end else if (accept) begin
      stable <= sync2;
      dcnt   <= '0;
    end else begin
      dcnt <= dcnt + DCW'(1);
    end
  end

  // Press coincides with the edge that raises stable, so pending and stable appear together.
  assign press = accept && sync2;

endmodule

// File: rtl/button_mmio_in.sv
// rtl/button_mmio_in.sv - memory-mapped up/down button input block with sticky flags and counters
module button_mmio_in
  import button_mmio_in_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DB_CYCLES = 1000000,
  parameter int               CNT_BITS  = 8,
  parameter logic [WIDTH-1:0] BASE_ADR  = WIDTH'(DEFAULT_BASE_ADR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic             hit,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic                up_stable;
  logic                up_press;
  logic                down_stable;
  logic                down_press;
  logic                up_pending;
  logic                down_pending;
  logic [CNT_BITS-1:0] up_cnt;
  logic [CNT_BITS-1:0] dn_cnt;
  reg_sel_e            sel;
  logic                wr_en;
  logic                clr_up_pend;
  logic                clr_down_pend;
  logic                clr_up_cnt;
  logic                clr_dn_cnt;
  logic [WIDTH-1:0]    status_word;
  logic [WIDTH-1:0]    rd_val;
  logic                unused_wdata;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_up_db (
    .clk    (clk),
    .reset  (reset),
    .raw    (up),
    .stable (up_stable),
    .press  (up_press)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_down_db (
    .clk    (clk),
    .reset  (reset),
    .raw    (down),
    .stable (down_stable),
    .press  (down_press)
  );

  assign hit   = (adr[WIDTH-1:4] == BASE_ADR[WIDTH-1:4]);
  assign sel   = decode_ofs(adr[3:0]);
  assign wr_en = memwrite && hit;

  assign clr_up_pend   = wr_en && (sel == REG_STATUS) && writedata[ST_UP_PENDING];
  assign clr_down_pend = wr_en && (sel == REG_STATUS) && writedata[ST_DOWN_PENDING];
  assign clr_up_cnt    = wr_en && (sel == REG_UPCNT);
  assign clr_dn_cnt    = wr_en && (sel == REG_DNCNT);

  assign unused_wdata = ^{writedata[WIDTH-1:4], writedata[1:0]};

  // Clear is applied first and the press on top of it, so a press is never lost.
  function automatic logic [CNT_BITS-1:0] cnt_next(input logic [CNT_BITS-1:0] cnt,
                                                   input logic clr,
                                                   input logic inc);
    logic [CNT_BITS-1:0] base;
    base = clr ? '0 : cnt;
    if (inc && (base != CNT_MAX)) begin
      return base + CNT_BITS'(1);
    end
    return base;
  endfunction

  always_comb begin
    status_word                  = '0;
    status_word[ST_UP_STABLE]    = up_stable;
    status_word[ST_DOWN_STABLE]  = down_stable;
    status_word[ST_UP_PENDING]   = up_pending;
    status_word[ST_DOWN_PENDING] = down_pending;
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      REG_STATUS: rd_val = status_word;
      REG_UPCNT:  rd_val = WIDTH'(up_cnt);
      REG_DNCNT:  rd_val = WIDTH'(dn_cnt);
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up_pending   <= 1'b0;
      down_pending <= 1'b0;
      up_cnt       <= '0;
      dn_cnt       <= '0;
    end else begin
      up_pending   <= up_press   | (up_pending   & ~clr_up_pend);
      down_pending <= down_press | (down_pending & ~clr_down_pend);
      up_cnt       <= cnt_next(up_cnt, clr_up_cnt, up_press);
      dn_cnt       <= cnt_next(dn_cnt, clr_dn_cnt, down_press);
    end
  end

  // Reads sample the pre-write register state, so a same-cycle write is not visible yet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      rdata <= (memread && hit) ? rd_val : '0;
      irq   <= up_pending | down_pending;
    end
  end

endmodule
